// File: rtl/vect_operand_loader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// vect_operand_loader
//
// Upstream feeder for the 96-element dot-product multiplier. Element pairs
// (feature, weight) arrive one per cycle over a valid/ready stream and are
// packed into VEC_LEN-wide feature and weight vectors. Two banks ping-pong:
// one fills while the other is held stable for the multiplier.
//
// Handshake semantics (both streams): a transfer happens on a rising CLK edge
// where valid and ready are both high. IN_READY and VEC_VALID are decoded from
// registers only, so neither depends combinationally on IN_VALID or VEC_READY.
//
// Ports:
//   CLK, RSTN            clock (rising edge), asynchronous active-low reset
//   IN_VALID / IN_READY  element-pair stream handshake
//   IN_FEATURE/IN_WEIGHT element pair, IN_LAST marks the final element
//   FEATURE_COL          feature vector to the multiplier (bank[rd_bank])
//   WEIGHT_ROW           weight vector to the multiplier (bank[rd_bank])
//   VEC_VALID/VEC_READY  vector-pair handshake toward the multiplier
//   LEN_ERR              one-cycle pulse when IN_LAST disagrees with length
//   VEC_COUNT            vectors delivered since reset (wraps)
// -----------------------------------------------------------------------------
module vect_operand_loader #(
    parameter int FEATURE_WIDTH = 5,
    parameter int WEIGHT_WIDTH  = 5,
    parameter int VEC_LEN       = 96,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     CLK,
    input  logic                     RSTN,
    input  logic                     IN_VALID,
    output logic                     IN_READY,
    input  logic [FEATURE_WIDTH-1:0] IN_FEATURE,
    input  logic [WEIGHT_WIDTH-1:0]  IN_WEIGHT,
    input  logic                     IN_LAST,
    output logic [FEATURE_WIDTH-1:0] FEATURE_COL [0:VEC_LEN-1],
    output logic [WEIGHT_WIDTH-1:0]  WEIGHT_ROW  [0:VEC_LEN-1],
    output logic                     VEC_VALID,
    input  logic                     VEC_READY,
    output logic                     LEN_ERR,
    output logic [CNT_WIDTH-1:0]     VEC_COUNT
);

    localparam int IDX_W = $clog2(VEC_LEN);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(VEC_LEN - 1);

    // Two storage banks; a bank is FILLING while wr_bank points at it and
    // full is clear, FULL while its full bit is set, otherwise EMPTY.
    logic [FEATURE_WIDTH-1:0] feat_bank [0:1][0:VEC_LEN-1];
    logic [WEIGHT_WIDTH-1:0]  wgt_bank  [0:1][0:VEC_LEN-1];

    logic             wr_bank;
    logic             rd_bank;
    logic [1:0]       full;
    logic [1:0]       full_nxt;
    logic [IDX_W-1:0] idx;
    logic             len_err_q;
    logic [CNT_WIDTH-1:0] vec_count_q;

    logic accept;
    logic rel;
    logic at_last;
    logic complete;
    logic early_last;

    assign IN_READY  = !full[wr_bank];
    assign VEC_VALID = full[rd_bank];
    assign LEN_ERR   = len_err_q;
    assign VEC_COUNT = vec_count_q;

    assign accept     = IN_VALID & IN_READY;
    assign rel        = VEC_VALID & VEC_READY;
    assign at_last    = (idx == IDX_LAST);
    assign complete   = accept & at_last;
    assign early_last = accept & IN_LAST & !at_last;

    // Completion and release never target the same bank in one cycle:
    // completion needs full[wr_bank]==0, release needs full[rd_bank]==1.
    always_comb begin
        full_nxt = full;
        if (rel) begin
            full_nxt[rd_bank] = 1'b0;
        end
        if (complete) begin
            full_nxt[wr_bank] = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b0;
            full        <= 2'b00;
            idx         <= '0;
            len_err_q   <= 1'b0;
            vec_count_q <= '0;
        end else begin
            full      <= full_nxt;
            len_err_q <= (complete & !IN_LAST) | early_last;
            if (complete) begin
                wr_bank <= ~wr_bank;
            end
            if (rel) begin
                rd_bank     <= ~rd_bank;
                vec_count_q <= vec_count_q + 1'b1;
            end
            // An early IN_LAST rewinds idx so the partial vector in this
            // bank is simply overwritten by the next elements.
            if (accept) begin
                if (at_last || IN_LAST) begin
                    idx <= '0;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < VEC_LEN; i++) begin
                    feat_bank[b][i] <= '0;
                    wgt_bank[b][i]  <= '0;
                end
            end
        end else if (accept) begin
            feat_bank[wr_bank][idx] <= IN_FEATURE;
            wgt_bank[wr_bank][idx]  <= IN_WEIGHT;
        end
    end

    always_comb begin
        for (int i = 0; i < VEC_LEN; i++) begin
            FEATURE_COL[i] = feat_bank[rd_bank][i];
            WEIGHT_ROW[i]  = wgt_bank[rd_bank][i];
        end
    end

endmodule
